// File: rtl/wb_bin_mult_seq_if.sv
// Wishbone slave bus bundle for wb_bin_mult_seq.
// Signals: wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i[3:0], wbs_dat_i[31:0],
//          wbs_adr_i[31:0] (master -> slave); wbs_ack_o, wbs_dat_o[31:0]
//          (slave -> master).
interface wb_bin_mult_seq_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_bin_mult_seq.sv
// Wishbone-slave sequential shift-add multiplier, one multiplier bit per cycle.
// Ports: wb_clk_i, wb_rst_i (async, active-high), wb (Wishbone slave bundle),
//        be_out[OUT_W-1:0] (registered product slice for the DAC pads),
//        busy_o (multiply running), done_o (sticky completion flag).
// Optional feature: define BIN_MULT_SIGNED_EN to implement CTRL.SIGNED
// (sign/magnitude multiply); otherwise the block is unsigned only.
module wb_bin_mult_seq #(
    parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned OUT_W        = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    wb_bin_mult_seq_if.slave  wb,
    output logic [OUT_W-1:0]  be_out,
    output logic              busy_o,
    output logic              done_o
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned PW    = 2 * WIDTH;

    localparam logic [2:0] OFF_CTRL    = 3'd0;
    localparam logic [2:0] OFF_A       = 3'd1;
    localparam logic [2:0] OFF_B       = 3'd2;
    localparam logic [2:0] OFF_STATUS  = 3'd3;
    localparam logic [2:0] OFF_RES_LO  = 3'd4;
    localparam logic [2:0] OFF_RES_HI  = 3'd5;
    localparam logic [2:0] OFF_OUT_SEL = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [PW-1:0]     mcand_q, mcand_d, acc_q, acc_d, sum_c;
    logic [WIDTH-1:0]  mplier_q, mplier_d, a_mag_c, b_mag_c;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [4:0]        out_sel_q, out_sel_d;
    logic [63:0]       result_q, result_d;
    logic              done_q, done_d, busy_q;
    logic              ack_q, ack_d;
    logic [31:0]       dat_q, dat_d;
    logic [OUT_W-1:0]  be_q, be_d;
    logic [10:0]       shamt_c;
    logic [2:0]        off_c;
    logic              hit_c, busy_c, start_c, ctrl_signed_c;
    logic              unused_c;
`ifdef BIN_MULT_SIGNED_EN
    logic              signed_q, signed_d, neg_q, neg_d;
`endif

    // Address LSBs and upper data/select bits are unused for narrow operands
    assign unused_c = ^{wb.wbs_adr_i[1:0], wb.wbs_dat_i, wb.wbs_sel_i};

`ifdef BIN_MULT_SIGNED_EN
    assign ctrl_signed_c = signed_q;
`else
    assign ctrl_signed_c = 1'b0;
`endif

    // Bus decode, register writes, FSM next state and shift-add datapath
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        out_sel_d = out_sel_q;
        result_d  = result_q;
        done_d    = done_q;
        ack_d     = 1'b0;
        dat_d     = '0;
        sum_c     = '0;
        a_mag_c   = a_q;
        b_mag_c   = b_q;
`ifdef BIN_MULT_SIGNED_EN
        signed_d  = signed_q;
        neg_d     = neg_q;
`endif
        off_c   = wb.wbs_adr_i[4:2];
        busy_c  = (state_q == RUN);
        // ack_q gate keeps acks one cycle wide and never back to back
        hit_c   = wb.wbs_stb_i & wb.wbs_cyc_i & ~ack_q &
                  (wb.wbs_adr_i[31:5] == BASE_ADDRESS[31:5]);
        start_c = hit_c & wb.wbs_we_i & (off_c == OFF_CTRL) & wb.wbs_sel_i[0] &
                  wb.wbs_dat_i[0] & ~busy_c;

        if (hit_c) begin
            ack_d = 1'b1;
            if (!wb.wbs_we_i) begin
                case (off_c)
                    OFF_CTRL:    dat_d = {30'd0, ctrl_signed_c, 1'b0};
                    OFF_A:       dat_d = 32'(a_q);
                    OFF_B:       dat_d = 32'(b_q);
                    OFF_STATUS:  dat_d = {30'd0, done_q, busy_c};
                    OFF_RES_LO:  dat_d = result_q[31:0];
                    OFF_RES_HI:  dat_d = result_q[63:32];
                    OFF_OUT_SEL: dat_d = {27'd0, out_sel_q};
                    default:     dat_d = '0;
                endcase
            end else begin
                case (off_c)
                    OFF_CTRL: begin
`ifdef BIN_MULT_SIGNED_EN
                        if (wb.wbs_sel_i[0] && !busy_c) signed_d = wb.wbs_dat_i[1];
`endif
                    end
                    OFF_A: begin
                        for (int i = 0; i < WIDTH; i++)
                            if (!busy_c && wb.wbs_sel_i[i/8]) a_d[i] = wb.wbs_dat_i[i];
                    end
                    OFF_B: begin
                        for (int i = 0; i < WIDTH; i++)
                            if (!busy_c && wb.wbs_sel_i[i/8]) b_d[i] = wb.wbs_dat_i[i];
                    end
                    OFF_STATUS: begin
                        if (wb.wbs_sel_i[0] && wb.wbs_dat_i[1]) done_d = 1'b0;
                    end
                    OFF_OUT_SEL: begin
                        if (wb.wbs_sel_i[0]) out_sel_d = wb.wbs_dat_i[4:0];
                    end
                    default: ;
                endcase
            end
        end

        // START latches operand magnitudes; sign of the product is kept aside
        if (start_c) begin
`ifdef BIN_MULT_SIGNED_EN
            if (wb.wbs_dat_i[1] && a_q[WIDTH-1]) a_mag_c = -a_q;
            if (wb.wbs_dat_i[1] && b_q[WIDTH-1]) b_mag_c = -b_q;
            neg_d = wb.wbs_dat_i[1] & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
`endif
            state_d  = RUN;
            done_d   = 1'b0;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = PW'(a_mag_c);
            mplier_d = b_mag_c;
        end

        // One partial product per cycle; completion overrides a same-edge DONE clear
        if (busy_c) begin
            sum_c    = acc_q + (mplier_q[0] ? mcand_q : '0);
            acc_d    = sum_c;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
`ifdef BIN_MULT_SIGNED_EN
                result_d = neg_q ? -64'(sum_c) : 64'(sum_c);
`else
                result_d = 64'(sum_c);
`endif
            end
        end

        // Slices past bit 63 shift out to zero
        shamt_c = 11'(out_sel_q) * 11'(OUT_W);
        be_d    = OUT_W'(result_q >> shamt_c);
    end

    // State and register file
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            out_sel_q <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
            be_q      <= '0;
`ifdef BIN_MULT_SIGNED_EN
            signed_q  <= 1'b0;
            neg_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            out_sel_q <= out_sel_d;
            result_q  <= result_d;
            done_q    <= done_d;
            busy_q    <= (state_d == RUN);
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            be_q      <= be_d;
`ifdef BIN_MULT_SIGNED_EN
            signed_q  <= signed_d;
            neg_q     <= neg_d;
`endif
        end
    end

    assign wb.wbs_ack_o = ack_q;
    assign wb.wbs_dat_o = dat_q;
    assign be_out       = be_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
endmodule

// File: tb/tb_wb_bin_mult_seq.sv
// Directed bench for wb_bin_mult_seq: Wishbone register access, multiply
// latency, busy protection, pad slicing and asynchronous reset.
`timescale 1ns/1ps
module tb_wb_bin_mult_seq;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned OUT_W = 8;
    localparam logic [31:0] BASE  = 32'h3000_0000;
`ifdef BIN_MULT_SIGNED_EN
    localparam bit SEN = 1'b1;
`else
    localparam bit SEN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [OUT_W-1:0] be_out;
    logic             busy_o, done_o;
    int               checks = 0;
    int               failures = 0;
    int               cyc_cnt = 0;
    int               t0 = 0;
    logic [63:0]      sb[$];
    logic [63:0]      last_prod = '0;

    wb_bin_mult_seq_if bus();

    wb_bin_mult_seq #(.BASE_ADDRESS(BASE), .WIDTH(WIDTH), .OUT_W(OUT_W)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb       (bus.slave),
        .be_out   (be_out),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                        input logic [3:0] sel, output logic [31:0] rdat, output logic acked);
        bus.wbs_adr_i = adr;
        bus.wbs_we_i  = we;
        bus.wbs_dat_i = wdat;
        bus.wbs_sel_i = sel;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        acked = 1'b0;
        rdat  = '0;
        for (int i = 0; i < 8 && !acked; i++) begin
            @(posedge clk); #1;
            if (bus.wbs_ack_o) begin
                acked = 1'b1;
                rdat  = bus.wbs_dat_o;
            end
        end
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
    endtask

    task automatic wr(input logic [4:0] off, input logic [31:0] d, input logic [3:0] sel);
        logic [31:0] r;
        logic        a;
        xfer(BASE + 32'(off), 1'b1, d, sel, r, a);
        chk($sformatf("wr_ack_%0h", off), 64'(a), 64'd1);
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] off, input logic [31:0] exp);
        logic [31:0] r;
        logic        a;
        xfer(BASE + 32'(off), 1'b0, '0, 4'hF, r, a);
        chk({tag, "_ack"}, 64'(a), 64'd1);
        chk(tag, 64'(r), 64'(exp));
    endtask

    function automatic logic [63:0] model(input logic [15:0] a, input logic [15:0] b, input bit sgn);
        logic signed [63:0] sa, sbv;
        if (sgn && SEN) begin
            sa  = {{48{a[15]}}, a};
            sbv = {{48{b[15]}}, b};
            return 64'(sa * sbv);
        end
        return {48'd0, a} * {48'd0, b};
    endfunction

    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] ctrl);
        wr(5'h04, 32'(a), 4'hF);
        wr(5'h08, 32'(b), 4'hF);
        wr(5'h00, 32'(ctrl), 4'hF);
        t0 = cyc_cnt;
        sb.push_back(model(a, b, ctrl[1]));
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy_o && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_busy_len"}, 64'(cyc_cnt - t0), 64'(WIDTH));
        chk({tag, "_done"}, 64'(done_o), 64'd1);
    endtask

    task automatic check_result(input string tag);
        logic [63:0] exp;
        chk({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
        exp = (sb.size() != 0) ? sb.pop_front() : '0;
        last_prod = exp;
        rd_chk({tag, "_lo"}, 5'h10, exp[31:0]);
        rd_chk({tag, "_hi"}, 5'h14, exp[63:32]);
    endtask

    initial begin
        logic [31:0] r;
        logic        a;
        logic [63:0] sh;
        logic [4:0]  sels[5];
        sels[0] = 5'd0; sels[1] = 5'd1; sels[2] = 5'd2; sels[3] = 5'd3; sels[4] = 5'd8;

        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'hF;
        bus.wbs_dat_i = '0;
        bus.wbs_adr_i = BASE;

        // Reset held with a live hit on the bus
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", 64'(bus.wbs_ack_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_be", 64'(be_out), 64'd0);
        chk("rst_dat", 64'(bus.wbs_dat_o), 64'd0);
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        #3 rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++)
            rd_chk($sformatf("rst_reg_%0d", i), 5'(i * 4), 32'd0);

        // Unsigned full-scale product
        start_op(16'hFFFF, 16'hFFFF, 2'b01);
        chk("u_busy_now", 64'(busy_o), 64'd1);
        wait_idle("u_ffff");
        check_result("u_ffff");
        rd_chk("u_status", 5'h0C, 32'h2);

        // DONE clear needs sel[0]
        wr(5'h0C, 32'h2, 4'hE);
        chk("done_sel_masked", 64'(done_o), 64'd1);
        wr(5'h0C, 32'h2, 4'hF);
        chk("done_cleared", 64'(done_o), 64'd0);

        // Signed mode (unsigned result when the feature is compiled out)
        start_op(16'hFFFD, 16'h0005, 2'b11);
        wait_idle("s_m3x5");
        check_result("s_m3x5");
        rd_chk("ctrl_signed_rb", 5'h00, SEN ? 32'h2 : 32'h0);
        start_op(16'h8000, 16'h8000, 2'b11);
        wait_idle("s_mostneg");
        check_result("s_mostneg");

        // Byte-lane write to A
        wr(5'h04, 32'h1234, 4'hF);
        wr(5'h04, 32'hAAAA, 4'b0001);
        rd_chk("a_bytelane", 5'h04, 32'h12AA);

        // Writes while busy: A/CTRL ignored, OUT_SEL applied
        start_op(16'h0003, 16'h0007, 2'b01);
        wr(5'h04, 32'h1234, 4'hF);
        wr(5'h00, 32'h1, 4'hF);
        wr(5'h18, 32'h2, 4'hF);
        rd_chk("busy_outsel_rb", 5'h18, 32'h2);
        wait_idle("busy_prot");
        rd_chk("busy_a_kept", 5'h04, 32'h3);
        check_result("busy_prot");

        // Pad slice over several OUT_SEL values, including past bit 63
        start_op(16'h1234, 16'h5678, 2'b01);
        wait_idle("slice");
        check_result("slice");
        for (int i = 0; i < 5; i++) begin
            wr(5'h18, 32'(sels[i]), 4'hF);
            @(posedge clk); #1;
            sh = last_prod >> (int'(sels[i]) * OUT_W);
            chk($sformatf("be_sel_%0d", sels[i]), 64'(be_out), 64'(sh[OUT_W-1:0]));
        end

        // Window miss is never acked; unmapped word reads 0
        xfer(BASE + 32'h20, 1'b0, '0, 4'hF, r, a);
        chk("miss_no_ack", 64'(a), 64'd0);
        wr(5'h1C, 32'hFFFF_FFFF, 4'hF);
        rd_chk("unmapped_rd", 5'h1C, 32'h0);

        // Asynchronous reset in the middle of RUN
        start_op(16'hFFFF, 16'h0002, 2'b01);
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midrst_busy", 64'(busy_o), 64'd0);
        chk("midrst_done", 64'(done_o), 64'd0);
        chk("midrst_be", 64'(be_out), 64'd0);
        sb.delete();
        #2 rst = 1'b0;
        @(posedge clk); #1;
        rd_chk("midrst_lo", 5'h10, 32'h0);
        rd_chk("midrst_hi", 5'h14, 32'h0);
        rd_chk("midrst_a", 5'h04, 32'h0);
        rd_chk("midrst_outsel", 5'h18, 32'h0);

        start_op(16'h0005, 16'h0006, 2'b01);
        wait_idle("after_rst");
        check_result("after_rst");
        @(posedge clk); #1;
        chk("after_rst_be", 64'(be_out), 64'h1E);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_bin_mult_seq.md
# wb_bin_mult_seq

Parametrised Wishbone-slave sequential binary multiplier: the next generation of the Caravel bin-mult peripheral. Firmware writes two operands over the Caravel Wishbone bus and starts a shift-add multiply, one bit per cycle. It then polls status and reads a 2·WIDTH-bit product. A selectable OUT_W-bit slice of the product drives the user IO pads for the external DAC.

## Interface
Parameters:
- BASE_ADDRESS, 32'h3000_0000, Wishbone base; block decodes a 32-byte window.
- WIDTH, 16, operand width; legal range 2..32.
- OUT_W, 8, width of the pad output slice; legal range 1..32.

Ports:
- wb_clk_i  in  1  single clock for all logic.
- wb_rst_i  in  1  reset; asynchronous, active-high.
- wbs_stb_i / wbs_cyc_i / wbs_we_i  in  1 each  Wishbone strobe, cycle, write enable.
- wbs_sel_i  in  4  byte enables.
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  byte address.
- wbs_ack_o  out  1  registered acknowledge.
- wbs_dat_o  out  32  read data.
- be_out  out  OUT_W  selected product slice, to the DAC pads.
- busy_o  out  1  multiply in progress.
- done_o  out  1  sticky completion flag.

## Operation
- Hit: stb&cyc&(adr[31:5]==BASE_ADDRESS[31:5]). Misses are never acked. Offsets 0x1C and unmapped words inside the window read 0, ignore writes, and are still acked.
- Register map (word offsets):
  - 0x00 CTRL: bit0 START, write-1 only, reads 0. bit1 SIGNED, R/W.
  - 0x04 A and 0x08 B: WIDTH bits, zero-extended on read. Writes honour wbs_sel_i per byte.
  - 0x0C STATUS: bit0 BUSY, RO. bit1 DONE, write-1-to-clear.
  - 0x10 RESULT_LO: product[31:0].
  - 0x14 RESULT_HI: product[63:32]. The product is extended to 64 bits, sign-extended when SIGNED, otherwise zero-extended.
  - 0x18 OUT_SEL: 5 bits, R/W.
- CTRL and STATUS writes act only when sel[0]=1.
- FSM states: IDLE, RUN.
  - IDLE→RUN on a START write. Operands and SIGNED are latched, BUSY=1, DONE cleared, iteration counter=0.
  - RUN: one partial product per cycle (add A when multiplier LSB=1, shift). Counter increments.
  - RUN→IDLE on the edge where counter reaches WIDTH-1. RESULT updates, BUSY=0, DONE=1.
- Signed mode: multiply magnitudes, then negate the product on the final edge if the operand signs differ. Latency is identical to unsigned mode. The most-negative operand is handled correctly (e.g. WIDTH=16: 0x8000×0x8000 = 0x40000000).
- While BUSY:
  - Writes to A, B, CTRL (including START) and OUT_SEL.. A, B and CTRL writes are acked and ignored.
  - OUT_SEL writes take effect.
  - RESULT holds the previous product.
- A DONE clear and a completion on the same edge: completion wins, DONE=1.
- be_out = (product64 >> (OUT_SEL·OUT_W))[OUT_W-1:0]. Slices at or beyond bit 64 output 0.

## Timing
- Reset values: all outputs 0. A, B, CTRL, OUT_SEL, RESULT are 0. FSM is IDLE.
- Ack:
  - wbs_ack_o rises one edge after a hit and stays high for exactly one cycle.
  - A new hit is accepted only while ack is low, so there are no back-to-back acks.
  - Read data is valid in the ack cycle. Write side effects commit on the ack-rising edge.
- Latency:
  - The START write commits at edge E0. busy_o is high from E0 for exactly WIDTH cycles.
  - At edge E0+WIDTH, busy_o falls and done_o and RESULT update together.
- be_out is registered. It follows a RESULT or OUT_SEL change one cycle later.
- Asserting wb_rst_i mid-RUN immediately aborts the operation and clears every register and output, with no clock needed.

## Configuration
- BIN_MULT_SIGNED_EN defined: CTRL.SIGNED is implemented as described above.
- Undefined: CTRL.SIGNED reads 0 and writes to it are ignored. Unsigned only, with zero extension. The sign and negate logic is removed.

## Test plan
- Reset: assert wb_rst_i asynchronously mid-cycle → all outputs 0; every register reads 0; no ack during reset.
- Unsigned, WIDTH=16: A=0xFFFF, B=0xFFFF, START → busy_o high exactly 16 cycles; RESULT_LO=0xFFFE0001, RESULT_HI=0; done_o=1.
- Signed (macro on): A=0xFFFD (−3), B=0x0005, SIGNED|START → RESULT_LO=0xFFFFFFF1, RESULT_HI=0xFFFFFFFF. Without the macro, the same stimulus gives 0x0004FFF1.
- Busy protection: during RUN, write A=0x1234 and START → both acked and ignored; result matches the original operands; busy_o not extended.
- Pad slice: product 0x0000_0000_ABCD_1234, OUT_SEL=1, OUT_W=8 → be_out=0x12. OUT_SEL=8 → 0x00.
- Reset mid-operation: assert wb_rst_i at cycle 5 of RUN → busy_o=0, done_o=0, RESULT=0. A fresh START then completes normally.
